// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: FSM encoding, wait-cycle range and memory-stage request register shared by the pipeline.
package dmem_responder_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } mem_req_t;
  function automatic logic addr_bad(input logic [31:0] addr, input logic [31:0] depth);
    return addr[1:0] != 2'b00 || {2'b00, addr[31:2]} >= depth;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: memory-stage request/response bus between pipeline and data memory.
interface dmem_responder_if;
  logic        req_M;
  logic        we_M;
  logic [31:0] addr_M;
  logic [31:0] wd_M;
  logic [3:0]  be_M;
  logic [31:0] rd_dm;
  logic        rd_valid;
  logic        stall;
  logic        access_err;
  modport master(output req_M, we_M, addr_M, wd_M, be_M, input rd_dm, rd_valid, stall, access_err);
  modport slave(input req_M, we_M, addr_M, wd_M, be_M, output rd_dm, rd_valid, stall, access_err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word memory with byte-enabled writes and a registered read port.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (en && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wd[8*i +: 8];
  // Only the read register is reset; stores leave it holding the last load.
  always_ff @(posedge clk)
    if (rst) rd <= '0;
    else if (en && !we) rd <= mem[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory responder that stalls the pipeline for WAIT_CYCLES+1 cycles per access.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_range
    $error("WAIT_CYCLES out of range");
  end
  logic [1:0]  state;
  logic [3:0]  cnt;
  mem_req_t    req_q;
  logic        acc, bad, commit, rd_valid_q, err_q, unused;
  logic [31:0] rd;
  assign bad = addr_bad(bus.addr_M, 32'(DEPTH_WORDS));
  assign acc = !rst && state != S_WAIT && bus.req_M;
  assign commit = !rst && state == S_WAIT && cnt == 4'd0;
  assign bus.stall = (acc && !bad) || (!rst && state == S_WAIT);
  assign bus.rd_valid = rd_valid_q;
  assign bus.access_err = err_q;
  assign bus.rd_dm = rd;
  assign unused = ^{req_q.addr[31:AW+2], req_q.addr[1:0]};
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      rd_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= acc && bad;
      rd_valid_q <= commit && !req_q.we;
      if (acc) begin
        state <= bad ? S_IDLE : S_WAIT;
        cnt <= bad ? 4'd0 : CNT_INIT;
      end else if (state == S_WAIT) begin
        state <= cnt == 4'd0 ? S_RESP : S_WAIT;
        cnt <= cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
      end else begin
        state <= S_IDLE;
      end
    end
  // Request is frozen at acceptance so bus changes during WAIT cannot disturb it.
  always_ff @(posedge clk)
    if (acc) req_q <= '{we: bus.we_M, addr: bus.addr_M, wd: bus.wd_M, be: bus.be_M};
  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk(clk),
    .rst(rst),
    .en(commit),
    .we(req_q.we),
    .be(req_q.be),
    .addr(req_q.addr[AW+1:2]),
    .wd(req_q.wd),
    .rd(rd)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of stall timing, load/store data, rejection and reset abort.
module tb_dmem_responder;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dmem_responder_if bus();
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic exp_v = 1'b0;
  logic exp_err = 1'b0;
  logic [31:0] exp_rd = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic st);
    @(negedge clk);
    check({tag, " stall"}, 32'(bus.stall), 32'(st));
    check({tag, " rd_valid"}, 32'(bus.rd_valid), 32'(exp_v));
    check({tag, " rd_dm"}, bus.rd_dm, exp_rd);
    check({tag, " access_err"}, 32'(bus.access_err), 32'(exp_err));
    @(posedge clk);
    #1;
    exp_v = 1'b0;
    exp_err = 1'b0;
  endtask
  task automatic idle(input string tag);
    bus.req_M = 1'b0;
    cyc(tag, 1'b0);
  endtask
  task automatic acc(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic ok, input logic [31:0] d);
    bus.req_M = 1'b1;
    bus.we_M = we;
    bus.addr_M = a;
    bus.wd_M = wd;
    bus.be_M = be;
    cyc(tag, ok);
    if (!ok) begin
      bus.req_M = 1'b0;
      exp_err = 1'b1;
      return;
    end
    bus.we_M = 1'($urandom);
    bus.addr_M = $urandom;
    bus.wd_M = $urandom;
    bus.be_M = 4'($urandom);
    repeat (W) cyc(tag, 1'b1);
    if (!we) begin
      exp_v = 1'b1;
      exp_rd = d;
    end
  endtask
  initial begin
    bus.req_M = 1'b1;
    bus.we_M = 1'b1;
    bus.addr_M = 32'h10;
    bus.wd_M = 32'h0BAD0BAD;
    bus.be_M = 4'hF;
    @(posedge clk);
    #1;
    cyc("reset", 1'b0);
    rst = 1'b0;
    idle("post_reset");
    acc("st10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0);
    acc("ld10", 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF);
    idle("ld10_resp");
    acc("st10_be3", 1'b1, 32'h10, 32'h00001234, 4'h3, 1'b1, 32'h0);
    acc("ld10_be3", 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD1234);
    idle("be3_resp");
    acc("st10_be0", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 1'b1, 32'h0);
    acc("ld10_be0", 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD1234);
    idle("be0_resp");
    acc("ld12_mis", 1'b0, 32'h12, 32'h0, 4'h0, 1'b0, 32'h0);
    idle("mis_err");
    acc("st11_mis", 1'b1, 32'h11, 32'h99999999, 4'hF, 1'b0, 32'h0);
    idle("mis_st_err");
    acc("ld10_after_mis", 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD1234);
    idle("mis_resp");
    acc("ld400_oor", 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, 32'h0);
    idle("oor_err");
    acc("st3fc", 1'b1, 32'h3FC, 32'hCAFEF00D, 4'hF, 1'b1, 32'h0);
    acc("ld3fc", 1'b0, 32'h3FC, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D);
    acc("oor_in_resp", 1'b0, 32'h400, 32'h0, 4'h0, 1'b0, 32'h0);
    idle("oor_resp_err");
    acc("st20", 1'b1, 32'h20, 32'h11112222, 4'hF, 1'b1, 32'h0);
    acc("ld20", 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h11112222);
    idle("ld20_resp");
    bus.req_M = 1'b1;
    bus.we_M = 1'b1;
    bus.addr_M = 32'h20;
    bus.wd_M = 32'h55AA55AA;
    bus.be_M = 4'hF;
    cyc("abort_T", 1'b1);
    bus.req_M = 1'b0;
    cyc("abort_w1", 1'b1);
    rst = 1'b1;
    cyc("abort_rst", 1'b0);
    rst = 1'b0;
    exp_rd = 32'h0;
    idle("abort_after");
    acc("ld20_abort", 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h11112222);
    idle("abort_resp");
    for (int i = 0; i < 4; i++) begin
      acc("b2b_st", 1'b1, 32'h40 + 32'(4*i), 32'hA5000000 + 32'(i), 4'hF, 1'b1, 32'h0);
      acc("b2b_ld", 1'b0, 32'h40 + 32'(4*i), 32'h0, 4'h0, 1'b1, 32'hA5000000 + 32'(i));
    end
    idle("b2b_end");
    idle("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the data memory array.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 1..15: stall cycles inserted per accepted access.
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset is synchronous and active-high.
REQ-005 Port req_M  input  1: memory-stage access request.
REQ-006 Port we_M  input  1: 1 = store, 0 = load.
REQ-007 Port addr_M  input  32: byte address; word index = addr_M[31:2].
REQ-008 Port wd_M  input  32: store data.
REQ-009 Port be_M  input  4: store byte enables; bit i enables wd_M[8i+7:8i].
REQ-010 Port rd_dm  output  32: load data, registered.
REQ-011 Port rd_valid  output  1: one-cycle pulse, rd_dm holds fresh load data.
REQ-012 Port stall  output  1: freeze request to the upstream pipeline.
REQ-013 Port access_err  output  1: one-cycle pulse, request rejected.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; encoding is free.
REQ-015 Acceptance: when the FSM is in IDLE or RESP and req_M=1, the request is sampled into internal registers (we, addr, wd, be).
REQ-016 Rejection: a request is rejected when addr_M[1:0]!=0 or word index >= DEPTH_WORDS.
- Rejected request: access_err=1 in the next cycle, no memory access, stall=0, FSM goes to IDLE.
REQ-017 Valid request accepted in cycle T: stall=1 combinationally in cycle T; FSM enters WAIT with counter = WAIT_CYCLES-1.
REQ-018 WAIT state: stall=1; counter decrements each cycle.
- At counter==0, the access is performed at that clock edge and the FSM enters RESP.
- Total stall cycles = WAIT_CYCLES+1, counting cycle T.
REQ-019 Store commit: write only bytes with be_M=1; be_M=4'b0000 performs no write but consumes the same cycles.
REQ-020 Load: rd_dm updates with the full addressed word at the commit edge; rd_valid=1 during RESP only if the access was a load.
REQ-021 Store completion: rd_valid=0 and rd_dm keeps its previous value.
REQ-022 RESP state: stall=0 unless a new valid req_M is accepted in that cycle (back-to-back, REQ-015/REQ-017). Otherwise the FSM returns to IDLE.
REQ-023 Inputs changing while in WAIT are ignored; the latched request completes unchanged.
REQ-024 Store then load to the same word, back-to-back, returns the newly written data.
REQ-025 Resulting load latency: with WAIT_CYCLES=N, rd_valid occurs in cycle T+N+1.

Reset
REQ-026 While rst=1: FSM=IDLE, counter=0, rd_dm=0, rd_valid=0, access_err=0, stall=0; req_M is ignored.
REQ-027 Reset during WAIT aborts the access: no store is committed and no rd_valid is produced.
REQ-028 Memory array contents are not reset.

Structure
REQ-029 FSM state encoding and the WAIT_CYCLES range limit shall live in the shared pipeline package, alongside the stage-register definitions.
REQ-030 The memory array shall be one sub-module, dmem_array: synchronous, 1 read/write port, byte-enabled write. All control logic stays in dmem_responder.

Verification
REQ-031 WAIT_CYCLES=2; store addr 0x10, wd 0xDEADBEEF, be 0xF at T0.
- stall high T0..T2; then load 0x10 at T3 gives stall high T3..T5, rd_valid at T6, rd_dm=0xDEADBEEF.
REQ-032 Word 0x10 = 0xDEADBEEF; store be=0x3, wd=0x00001234.
- A following load returns 0xDEAD1234.
REQ-033 Load addr 0x12 (misaligned):
- access_err pulse next cycle, stall stays 0, memory unchanged.
REQ-034 Load addr 4*DEPTH_WORDS (out of range):
- access_err pulse, no rd_valid.
REQ-035 Store 0x20 = 0x55AA55AA, then rst=1 for one cycle during WAIT; afterwards load 0x20:
- returns the prior value (not 0x55AA55AA); no rd_valid from the aborted access.
REQ-036 Hold req_M=1 continuously with alternating load/store:
- each RESP cycle accepts the next request.
- exactly WAIT_CYCLES+1 stall cycles per access, with no idle gap.
